// File: rtl/pc_ir_unit.sv
// Program counter and instruction register for the CU-sequenced datapath.
// Also drives the shared memory address and counts IR loads with saturation.
module pc_ir_unit #(
    parameter int unsigned    AW       = 16,
    parameter logic [AW-1:0]  RESET_PC = '0,
    parameter int unsigned    CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             il_in,
    input  logic [1:0]       ps_in,
    input  logic             mm_in,
    input  logic [15:0]      a_in,
    input  logic [15:0]      mem_rdata_in,
    output logic [AW-1:0]    mem_addr_out,
    output logic [15:0]      ins_out,
    output logic [AW-1:0]    pc_out,
    output logic             ir_valid_out,
    output logic [CNT_W-1:0] fetch_cnt_out
);

    localparam logic [AW-1:0]    PC_ONE  = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [AW-1:0]    r_pc;
    logic [15:0]      r_ir;
    logic             r_valid;
    logic [CNT_W-1:0] r_cnt;

    logic [5:0]       w_off6;
    logic [15:0]      w_off16;
    logic [AW-1:0]    w_off;
    logic [AW-1:0]    w_pc_next;

    // Extend to 16 bits first so AW below 6 still slices cleanly.
    assign w_off6  = {r_ir[8:6], r_ir[2:0]};
    assign w_off16 = {{10{w_off6[5]}}, w_off6};
    assign w_off   = w_off16[AW-1:0];

    always_comb begin
        w_pc_next = r_pc;
        unique case (ps_in)
            2'b00: w_pc_next = r_pc;
            2'b01: w_pc_next = r_pc + PC_ONE;
            2'b10: w_pc_next = r_pc + w_off;
            2'b11: w_pc_next = a_in[AW-1:0];
            default: w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_pc <= w_pc_next;
            if (il_in) begin
                r_ir    <= mem_rdata_in;
                r_valid <= 1'b1;
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
            end
        end
    end

    assign mem_addr_out  = mm_in ? r_pc : a_in[AW-1:0];
    assign ins_out       = r_ir;
    assign pc_out        = r_pc;
    assign ir_valid_out  = r_valid;
    assign fetch_cnt_out = r_cnt;

endmodule

// File: tb/tb_pc_ir_unit.sv
// Directed bench for pc_ir_unit: a 16-bit instance and an 8-bit/2-bit-counter
// instance share stimulus and are compared against an arithmetic model each cycle.
module tb_pc_ir_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        il, mm;
    logic [1:0]  ps;
    logic [15:0] a, rd;

    logic [15:0] addr0, ins0, pc0, cnt0;
    logic        v0;
    logic [7:0]  addr1, pc1;
    logic [15:0] ins1;
    logic        v1;
    logic [1:0]  cnt1;

    int n_chk = 0;
    int n_err = 0;

    // model state
    int          m_pc0, m_pc1, m_c0, m_c1;
    logic [15:0] m_ir;
    logic        m_v;

    always #5 clk = ~clk;

    pc_ir_unit #(.AW(16), .RESET_PC(16'h0010), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .il_in(il), .ps_in(ps), .mm_in(mm), .a_in(a),
        .mem_rdata_in(rd), .mem_addr_out(addr0), .ins_out(ins0), .pc_out(pc0),
        .ir_valid_out(v0), .fetch_cnt_out(cnt0)
    );

    pc_ir_unit #(.AW(8), .RESET_PC(8'h10), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .il_in(il), .ps_in(ps), .mm_in(mm), .a_in(a),
        .mem_rdata_in(rd), .mem_addr_out(addr1), .ins_out(ins1), .pc_out(pc1),
        .ir_valid_out(v1), .fetch_cnt_out(cnt1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc0 = 'h10; m_pc1 = 'h10; m_ir = '0; m_v = 1'b0; m_c0 = 0; m_c1 = 0;
    endtask

    function automatic int next_pc(input int pc, input int mask, input logic [1:0] sel,
                                   input logic [15:0] ir, input logic [15:0] tgt);
        logic [5:0] o6;
        int off;
        o6  = {ir[8:6], ir[2:0]};
        off = int'(o6);
        if (off > 31) off -= 64;
        case (sel)
            2'd1:    return (pc + 1) & mask;
            2'd2:    return (pc + off) & mask;
            2'd3:    return int'(tgt) & mask;
            default: return pc;
        endcase
    endfunction

    // One clock: drive inputs, then advance the model over the edge.
    task automatic cyc(input logic i_il, input logic [1:0] i_ps, input logic i_mm,
                       input logic [15:0] i_a, input logic [15:0] i_rd);
        int np0, np1;
        il = i_il; ps = i_ps; mm = i_mm; a = i_a; rd = i_rd;
        np0 = next_pc(m_pc0, 'hFFFF, ps, m_ir, a);
        np1 = next_pc(m_pc1, 'hFF, ps, m_ir, a);
        @(posedge clk);
        #1;
        m_pc0 = np0; m_pc1 = np1;
        if (i_il) begin
            m_ir = i_rd; m_v = 1'b1;
            if (m_c0 < 'hFFFF) m_c0++;
            if (m_c1 < 3) m_c1++;
        end
    endtask

    always @(negedge clk) begin
        chk("addr0", 32'(addr0), mm ? m_pc0 : 32'(a));
        chk("pc0",   32'(pc0),   m_pc0);
        chk("ins0",  32'(ins0),  32'(m_ir));
        chk("vld0",  32'(v0),    32'(m_v));
        chk("cnt0",  32'(cnt0),  m_c0);
        chk("addr1", 32'(addr1), mm ? m_pc1 : 32'(a[7:0]));
        chk("pc1",   32'(pc1),   m_pc1);
        chk("ins1",  32'(ins1),  32'(m_ir));
        chk("vld1",  32'(v1),    32'(m_v));
        chk("cnt1",  32'(cnt1),  m_c1);
    end

    initial begin
        rst_n = 1'b0; il = 1'b0; ps = 2'b00; mm = 1'b1; a = '0; rd = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_pc",   32'(pc0),   32'h0010);
        chk("rst_ins",  32'(ins0),  32'h0000);
        chk("rst_vld",  32'(v0),    32'h0);
        chk("rst_cnt",  32'(cnt0),  32'h0);
        chk("rst_addr", 32'(addr0), 32'h0010);

        // fetch then increment
        cyc(1'b1, 2'b00, 1'b1, 16'h0000, 16'h0A53);
        chk("f_ins", 32'(ins0), 32'h0A53);
        chk("f_pc",  32'(pc0),  32'h0010);
        chk("f_vld", 32'(v0),   32'h1);
        chk("f_cnt", 32'(cnt0), 32'h1);
        cyc(1'b0, 2'b01, 1'b1, 16'h0000, 16'h0000);
        chk("inc_pc", 32'(pc0), 32'h0011);

        // branch -4 from 0020
        cyc(1'b0, 2'b11, 1'b1, 16'h0020, 16'h0000);
        cyc(1'b1, 2'b00, 1'b1, 16'h0000, 16'h01C4);
        cyc(1'b0, 2'b10, 1'b1, 16'h0000, 16'h0000);
        chk("brn_pc",  32'(pc0), 32'h001C);
        chk("brn_pc8", 32'(pc1), 32'h1C);

        // branch +31 from FFF0 wraps
        cyc(1'b0, 2'b11, 1'b1, 16'hFFF0, 16'h0000);
        cyc(1'b1, 2'b00, 1'b1, 16'h0000, 16'h00C7);
        cyc(1'b0, 2'b10, 1'b1, 16'h0000, 16'h0000);
        chk("brp_pc",  32'(pc0), 32'h000F);
        chk("brp_pc8", 32'(pc1), 32'h0F);

        // branch -1 from 0 wraps to max, then increment wraps to 0
        cyc(1'b0, 2'b11, 1'b1, 16'h0000, 16'h0000);
        cyc(1'b1, 2'b00, 1'b1, 16'h0000, 16'h01C7);
        cyc(1'b0, 2'b10, 1'b1, 16'h0000, 16'h0000);
        chk("bm1_pc", 32'(pc0), 32'hFFFF);
        cyc(1'b0, 2'b01, 1'b1, 16'h0000, 16'h0000);
        chk("wrap_pc", 32'(pc0), 32'h0000);

        // jump and data addressing
        cyc(1'b0, 2'b11, 1'b1, 16'h1234, 16'h0000);
        chk("jmp_pc", 32'(pc0), 32'h1234);
        cyc(1'b0, 2'b00, 1'b0, 16'hABCD, 16'h0000);
        chk("dat_addr",  32'(addr0), 32'hABCD);
        chk("dat_addr8", 32'(addr1), 32'hCD);
        cyc(1'b0, 2'b00, 1'b1, 16'hABCD, 16'h0000);
        chk("pc_addr", 32'(addr0), 32'h1234);

        // simultaneous load and increment
        cyc(1'b0, 2'b11, 1'b1, 16'h0005, 16'h0000);
        cyc(1'b1, 2'b01, 1'b1, 16'h0000, 16'hBEEF);
        chk("sim_ins", 32'(ins0), 32'hBEEF);
        chk("sim_pc",  32'(pc0),  32'h0006);
        chk("sim_cnt", 32'(cnt0), 32'h5);

        // halt keeps everything frozen
        repeat (3) cyc(1'b0, 2'b00, 1'b1, 16'h0000, 16'h1111);
        chk("hlt_pc", 32'(pc0), 32'h0006);

        // asynchronous reset mid-cycle with an update pending
        il = 1'b1; ps = 2'b01; rd = 16'h7777;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_pc",   32'(pc0),  32'h0010);
        chk("arst_ins",  32'(ins0), 32'h0000);
        chk("arst_vld",  32'(v0),   32'h0);
        chk("arst_cnt",  32'(cnt0), 32'h0);
        chk("arst_cnt8", 32'(cnt1), 32'h0);
        @(posedge clk);
        #1;
        il = 1'b0; ps = 2'b00;
        rst_n = 1'b1;

        // saturation on the 2-bit counter
        cyc(1'b1, 2'b00, 1'b1, 16'h0000, 16'h0001);
        chk("sat1", 32'(cnt1), 32'h1);
        cyc(1'b1, 2'b00, 1'b1, 16'h0000, 16'h0002);
        chk("sat2", 32'(cnt1), 32'h2);
        cyc(1'b1, 2'b00, 1'b1, 16'h0000, 16'h0003);
        chk("sat3", 32'(cnt1), 32'h3);
        cyc(1'b1, 2'b00, 1'b1, 16'h0000, 16'h0004);
        chk("sat4", 32'(cnt1), 32'h3);
        cyc(1'b1, 2'b00, 1'b1, 16'h0000, 16'h0005);
        chk("sat5", 32'(cnt1), 32'h3);
        chk("sat_w", 32'(cnt0), 32'h5);

        cyc(1'b0, 2'b00, 1'b1, 16'h0000, 16'h0000);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pc_ir_unit.md
Name: pc_ir_unit

Overview:
Instruction-side datapath block driven by the control unit: holds the program counter (PC) and instruction register (IR).
- Consumes the CU's il/ps/mm controls and supplies the 16-bit instruction word back to the CU.
- Drives the shared memory address (PC or register-A bus), executes increment/branch/jump PC updates, and keeps a saturating fetch counter for debug/performance.

Parameters:
AW, 16, PC and memory address width (4..16)
RESET_PC, 0, PC value after reset (AW bits)
CNT_W, 16, width of fetch counter (2..32)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
il_in  input  1  IR load enable (CU il_out)
ps_in  input  2  PC select: 00 hold, 01 increment, 10 branch, 11 jump (CU ps_out)
mm_in  input  1  memory address select: 1 = PC, 0 = a_in (CU mm_out)
a_in  input  16  register file A bus (jump target / data address)
mem_rdata_in  input  16  memory read data (combinational read of mem_addr_out)
mem_addr_out  output  AW  memory address
ins_out  output  16  current IR contents (to CU ins_in)
pc_out  output  AW  current PC
ir_valid_out  output  1  IR has been loaded at least once since reset
fetch_cnt_out  output  CNT_W  number of IR loads since reset, saturating

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk. While rst_n=0: PC=RESET_PC, IR=16'h0000, ir_valid_out=0, fetch_cnt_out=0. mem_addr_out follows the mux below (RESET_PC if mm_in=1). Reset asserted mid-operation overrides any pending update on that edge.
- mem_addr_out is combinational: mm_in=1 -> PC; mm_in=0 -> a_in[AW-1:0] (upper bits truncated).
- IR, registered: on a rising edge with il_in=1, IR <= mem_rdata_in. ins_out = IR with no further delay; the new instruction is visible in the cycle after the fetch edge. On il_in=1, ir_valid_out <= 1 and stays 1 until reset.
- Fetch counter: on il_in=1, fetch_cnt_out <= fetch_cnt_out+1; saturates at all-ones and does not wrap.
- PC update, registered, on every rising edge:
  - 00: hold.
  - 01: PC <= PC+1.
  - 10: PC <= PC + sext(off6), where off6 = {IR[8:6], IR[2:0]} is two's complement in -32..+31, sign-extended to AW.
  - 11: PC <= a_in[AW-1:0].
- All PC arithmetic is modulo 2^AW. Wrap-around (max+1 -> 0, 0-1 -> max) is legal and silent.
- Branch offset uses the IR value held before the edge, i.e. the currently executing instruction. The PC used is the pre-edge PC, i.e. the address of that instruction, since the CU issues no increment during fetch.
- Simultaneous il_in=1 and ps_in!=00: both take effect on the same edge. IR loads mem_rdata_in addressed by the pre-edge mem_addr_out; PC updates independently.
- No internal state machine beyond these registers. Sequencing belongs to the CU: fetch cycle has il=1, ps=00, mm=1; execute cycle has il=0 and the chosen ps.
- Halt: the CU holds ps=00 and il=0. PC, IR and the counter remain frozen indefinitely.

Test Plan:
1. Reset with RESET_PC=16'h0010, then release -> pc_out=0010, ins_out=0000, ir_valid_out=0, fetch_cnt_out=0; with mm_in=1, mem_addr_out=0010.
2. Fetch then increment: mem_rdata_in=16'h0A53, il=1/ps=00/mm=1 for one cycle, then il=0/ps=01 -> after edge 1: ins_out=0A53, pc=0010, ir_valid=1, cnt=1; after edge 2: pc=0011.
3. Branch negative: IR loaded with IR[8:6]=3'b111, IR[2:0]=3'b100 (off=-4), PC=0020, ps=10 -> pc=001C. Repeat with off=+31 from PC=FFF0 -> pc=000F (wrap).
4. Jump and data address: ps=11, a_in=1234 -> pc=1234. With mm_in=0, a_in=ABCD -> mem_addr_out=ABCD combinationally; mm_in=1 -> mem_addr_out=pc.
5. Simultaneous: PC=0005, il=1, ps=01, mem_rdata_in=BEEF -> next cycle ins_out=BEEF, pc=0006, cnt+1. Assert rst_n=0 mid-cycle -> outputs return to reset values immediately, without waiting for clk.
6. Saturation: CNT_W=2, il=1 for 5 cycles -> fetch_cnt_out 1,2,3,3,3.
